// File: rtl/temporizador_compartilhado_pkg.sv
// Shared timer package: FSM states, default prescaler divisor and the round-robin pick.
package temporizador_compartilhado_pkg;

    typedef enum logic [1:0] {OCIOSO, CARGA, CONTANDO, FIM} estado_t;

    localparam int DIVISOR_DEF = 50_000_000;
    localparam int MAX_REQ     = 8;

    // First set bit at or above ptr, wrapping inside the n active channels.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0] ptr, input int n);
        logic [2:0] sel;
        logic       found;
        int         j;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = (int'(ptr) + i) % n;
            if (i < n && !found && req[j]) begin
                sel   = 3'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/temporizador_compartilhado_if.sv
// Requester-side bus of the shared timer; TEMPORIZADOR_PAUSA_EN adds the pausa line.
interface temporizador_compartilhado_if #(
    parameter int N_REQ = 4,
    parameter int DUR_W = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DUR_W-1:0] duracao;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       fim;
    logic                   ocupado;
    logic                   tempo;
    logic [DUR_W-1:0]       restante;
`ifdef TEMPORIZADOR_PAUSA_EN
    logic                   pausa;

    modport master (output req, duracao, pausa,
                    input  grant, fim, ocupado, tempo, restante);
    modport slave  (input  req, duracao, pausa,
                    output grant, fim, ocupado, tempo, restante);
`else
    modport master (output req, duracao,
                    input  grant, fim, ocupado, tempo, restante);
    modport slave  (input  req, duracao,
                    output grant, fim, ocupado, tempo, restante);
`endif
endinterface

// File: rtl/temporizador_compartilhado_divisor_tick.sv
// Tick prescaler: counts 0..DIVISOR-1 while enabled, tempo on the last count.
module divisor_tick #(
    parameter int DIVISOR = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tempo
);
    localparam int            CW   = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign tempo = en && (cnt == LAST);

endmodule

// File: rtl/temporizador_compartilhado.sv
// Round-robin arbiter sharing one tick-based countdown among N_REQ requesters.
// Optional TEMPORIZADOR_PAUSA_EN: pausa freezes counting while in CONTANDO.
module temporizador_compartilhado
    import temporizador_compartilhado_pkg::*;
#(
    parameter int DIVISOR = DIVISOR_DEF,
    parameter int N_REQ   = 4,
    parameter int DUR_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    temporizador_compartilhado_if.slave bus
);
    estado_t          estado, estado_n;
    logic [2:0]       idx, idx_n, ptr, ptr_n, prox;
    logic [DUR_W-1:0] rest, rest_n, dur_sel;
    logic [N_REQ-1:0] fim_q, fim_n;
    logic             tick, conta, pausa, req_dono, dono_ativo;

`ifdef TEMPORIZADOR_PAUSA_EN
    assign pausa = bus.pausa;
`else
    assign pausa = 1'b0;
`endif

    assign conta      = (estado == CONTANDO) && !pausa;
    assign req_dono   = bus.req[idx];
    assign dur_sel    = bus.duracao[idx*DUR_W +: DUR_W];
    assign prox       = (idx == 3'(N_REQ - 1)) ? 3'd0 : idx + 3'd1;
    assign dono_ativo = (estado == CARGA) || (estado == CONTANDO);

    divisor_tick #(.DIVISOR(DIVISOR)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (estado != CONTANDO),
        .en      (conta),
        .tempo   (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) estado <= OCIOSO;
        else          estado <= estado_n;
    end

    always_comb begin
        estado_n = estado;
        idx_n    = idx;
        ptr_n    = ptr;
        rest_n   = rest;
        fim_n    = '0;
        case (estado)
            OCIOSO: if (|bus.req) begin
                idx_n    = rr_pick(MAX_REQ'(bus.req), ptr, N_REQ);
                estado_n = CARGA;
            end
            CARGA: if (!req_dono) begin
                estado_n = OCIOSO;
                rest_n   = '0;
                ptr_n    = prox;
            end else begin
                rest_n   = dur_sel;
                estado_n = (dur_sel == '0) ? FIM : CONTANDO;
            end
            // Abandon wins over a coincident tick.
            CONTANDO: if (!req_dono) begin
                estado_n = OCIOSO;
                rest_n   = '0;
                ptr_n    = prox;
            end else if (tick && rest != '0) begin
                rest_n = rest - 1'b1;
                if (rest == DUR_W'(1)) estado_n = FIM;
            end
            FIM: begin
                fim_n    = N_REQ'(1) << idx;
                ptr_n    = prox;
                estado_n = OCIOSO;
            end
            default: estado_n = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx   <= '0;
            ptr   <= '0;
            rest  <= '0;
            fim_q <= '0;
        end else begin
            idx   <= idx_n;
            ptr   <= ptr_n;
            rest  <= rest_n;
            fim_q <= fim_n;
        end
    end

    assign bus.grant    = dono_ativo ? (N_REQ'(1) << idx) : '0;
    assign bus.fim      = fim_q;
    assign bus.ocupado  = (estado != OCIOSO);
    assign bus.tempo    = tick;
    assign bus.restante = rest;

endmodule
